// File: rtl/sys_clk_gen.sv
// sys_clk_gen: run/step/halt clock-enable generator for a soft CPU core.
// Produces a registered one-cycle clk_en pulse every div+1 cycles in RUN,
// one pulse per qualified push-button press in STEP, and nothing in HALT.
// Also keeps a wrapping count of issued pulses and drives two board LEDs.
// Optional feature: define SYS_CLK_GEN_DEBOUNCE_EN to debounce step_btn
// (DEB_CYCLES stable cycles for both press and release); otherwise every
// synchronised rising edge of step_btn is a step.
module sys_clk_gen #(
   parameter int unsigned DIV_W      = 24,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       mode,
   input  logic             step_btn,
   output logic             clk_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [1:0]       led_n
);

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_STEP = 2'b01;

   logic [DIV_W-1:0] cnt;
   logic             btn_s1;
   logic             btn_s2;
   logic             step_rise_c;

   // Two-flop synchroniser for the asynchronous push-button
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         btn_s1 <= step_btn;
         btn_s2 <= btn_s1;
      end
   end

`ifdef SYS_CLK_GEN_DEBOUNCE_EN
   localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [DEB_W-1:0] deb_cnt;
   logic             deb_level;
   logic             deb_level_d;

   // Accept a new button level only after it has differed from the
   // accepted level for DEB_CYCLES consecutive cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_cnt     <= '0;
         deb_level   <= 1'b0;
         deb_level_d <= 1'b0;
      end else begin
         deb_level_d <= deb_level;
         if (btn_s2 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level <= btn_s2;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   assign step_rise_c = deb_level & ~deb_level_d;
`else
   logic        btn_s2_d;
   logic [31:0] deb_cycles_unused;

   // Delayed synchronised level for raw rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s2_d <= 1'b0;
      end else begin
         btn_s2_d <= btn_s2;
      end
   end

   assign step_rise_c       = btn_s2 & ~btn_s2_d;
   assign deb_cycles_unused = 32'(DEB_CYCLES);
`endif

   // Divider and enable generation; non-RUN modes park cnt at 0 so any
   // mode transition restarts the count, and a step edge seen outside
   // STEP is simply dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         clk_en <= 1'b0;
      end else begin
         case (mode)
            MODE_RUN: begin
               if (cnt >= div) begin
                  cnt    <= '0;
                  clk_en <= 1'b1;
               end else begin
                  cnt    <= cnt + DIV_W'(1);
                  clk_en <= 1'b0;
               end
            end
            MODE_STEP: begin
               cnt    <= '0;
               clk_en <= step_rise_c;
            end
            default: begin
               cnt    <= '0;
               clk_en <= 1'b0;
            end
         endcase
      end
   end

   // Pulse counter and LEDs; led_n[0] holds the inverted heartbeat
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         led_n     <= 2'b11;
      end else begin
         if (clk_en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            led_n[0]  <= ~led_n[0];
         end
         led_n[1] <= (mode == MODE_RUN);
      end
   end

endmodule
